dmem_responder: RTL



---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_byte_ram.sv | 32 +++
 rtl/dmem_responder.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the dmem responder slice.
// Holds the RV32I load/store size codes, the responder state encoding and
// the word/lane geometry used by the responder and its byte-lane RAM.
package dmem_pkg;

    localparam int WORD_W    = 32;
    localparam int NUM_LANES = 4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

endpackage

// File: rtl/dmem_byte_ram.sv
// Single-port 2**ADDR_WIDTH x 32 synchronous RAM with per-byte write enables
// and a registered read port. Contents are never reset.
// Ports:
//   clk_i    clock
//   we_i     byte-lane write enables, lane 0 = bits [7:0]
//   addr_i   word address (shared by read and write)
//   wdata_i  write data, lane-aligned
//   rdata_o  registered read data of addr_i from the previous edge
module dmem_byte_ram
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk_i,
    input  logic [NUM_LANES-1:0]  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [WORD_W-1:0]     wdata_i,
    output logic [WORD_W-1:0]     rdata_o
);

    logic [WORD_W-1:0] mem_q [2**ADDR_WIDTH];

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NUM_LANES; i++) begin
            if (we_i[i]) begin
                mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
        rdata_o <= mem_q[addr_i];
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the CPU memory stage: accepts one RV32I
// load/store at a time, inserts WAIT_CYCLES wait states, performs the
// byte/half/word access and returns extended load data or an error flag.
//
// state  | meaning
// IDLE   | ready for a request
// WAIT   | counting wait states before the array access
// ACCESS | one cycle: store lanes written, or load data extended
// RESP   | response presented until the requester takes it
//
// Ports:
//   clk_i, reset_i (async, active-low)
//   req_valid_i/req_ready_o, req_write_i, req_addr_i, req_wdata_i, req_funct3_i
//   rsp_valid_o/rsp_ready_i, rsp_rdata_o, rsp_error_o
//   busy_o  high whenever a transaction is in flight
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [31:0]       req_addr_i,
    input  logic [31:0]       req_wdata_i,
    input  logic [2:0]        req_funct3_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [31:0]       rsp_rdata_o,
    output logic              rsp_error_o,
    output logic              busy_o
);

    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    write_q, write_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [1:0]              lane_q, lane_d;
    logic [2:0]              f3_q, f3_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    error_q, error_d;

    logic                    accept;
    logic                    req_err;
    logic [ADDR_WIDTH-1:0]   ram_addr;
    logic [NUM_LANES-1:0]    ram_we;
    logic [WORD_W-1:0]       ram_rdata;
    logic [NUM_LANES-1:0]    st_be;
    logic [WORD_W-1:0]       st_wdata;
    logic [7:0]              ld_byte;
    logic [15:0]             ld_half;
    logic [WORD_W-1:0]       ld_data;

    assign req_ready_o = (state_q == ST_IDLE) && reset_i;
    assign busy_o      = (state_q != ST_IDLE);
    assign rsp_valid_o = (state_q == ST_RESP);
    assign rsp_rdata_o = rdata_q;
    assign rsp_error_o = error_q;
    assign accept      = req_valid_i && req_ready_o;

    always_comb begin
        req_err = 1'b0;
        if ((req_addr_i >> (ADDR_WIDTH + 2)) != 32'd0) begin
            req_err = 1'b1;
        end
        if (req_write_i) begin
            case (req_funct3_i)
                F3_B:    ;
                F3_H:    if (req_addr_i[0]) req_err = 1'b1;
                F3_W:    if (req_addr_i[1:0] != 2'b00) req_err = 1'b1;
                default: req_err = 1'b1;
            endcase
        end else begin
            case (req_funct3_i)
                F3_B, F3_BU: ;
                F3_H, F3_HU: if (req_addr_i[0]) req_err = 1'b1;
                F3_W:        if (req_addr_i[1:0] != 2'b00) req_err = 1'b1;
                default:     req_err = 1'b1;
            endcase
        end
    end

    // In IDLE the RAM is addressed straight from the request so the registered
    // read is already valid when ACCESS is entered, even with no wait states.
    assign ram_addr = (state_q == ST_IDLE) ? req_addr_i[ADDR_WIDTH+1:2] : idx_q;

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = wdata_q;
        case (f3_q)
            F3_B: begin
                st_be    = 4'b0001 << lane_q;
                st_wdata = {4{wdata_q[7:0]}};
            end
            F3_H: begin
                st_be    = 4'b0011 << {lane_q[1], 1'b0};
                st_wdata = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
    end

    assign ram_we = (state_q == ST_ACCESS && write_q && !error_q) ? st_be : '0;

    always_comb begin
        case (lane_q)
            2'd0:    ld_byte = ram_rdata[7:0];
            2'd1:    ld_byte = ram_rdata[15:8];
            2'd2:    ld_byte = ram_rdata[23:16];
            default: ld_byte = ram_rdata[31:24];
        endcase
        ld_half = lane_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
        ld_data = ram_rdata;
        case (f3_q)
            F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   ld_data = {24'd0, ld_byte};
            F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            F3_HU:   ld_data = {16'd0, ld_half};
            default: ld_data = ram_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        idx_d   = idx_q;
        lane_d  = lane_q;
        f3_d    = f3_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        error_d = error_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    write_d = req_write_i;
                    idx_d   = req_addr_i[ADDR_WIDTH+1:2];
                    lane_d  = req_addr_i[1:0];
                    f3_d    = req_funct3_i;
                    wdata_d = req_wdata_i;
                    rdata_d = 32'd0;
                    error_d = req_err;
                    // Rejected requests take one pass through ACCESS (with the
                    // write suppressed) so their response arrives one edge
                    // after accept rather than on the accept edge itself.
                    if (req_err) begin
                        state_d = ST_ACCESS;
                    end else if (WAIT_CYCLES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_INIT;
                    end else begin
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ACCESS: begin
                rdata_d = (write_q || error_q) ? 32'd0 : ld_data;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
            idx_q   <= '0;
            lane_q  <= 2'd0;
            f3_q    <= 3'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            idx_q   <= idx_d;
            lane_q  <= lane_d;
            f3_q    <= f3_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
        end
    end

    dmem_byte_ram #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (st_wdata),
        .rdata_o (ram_rdata)
    );

endmodule
